frame_wr_ctrl: RTL

FRAME_WR_CTRL -- requirements
Module: frame_wr_ctrl

---
 rtl/frame_buf_pkg.sv | 20 ++
 rtl/cdc_sync2.sv | 21 ++
 rtl/frame_wr_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/frame_buf_pkg.sv
// Shared definitions for the camera frame-buffer write path: default geometry,
// write-controller state encoding and the frame size helper.
package frame_buf_pkg;

    localparam int DEF_IMAGE_WIDTH  = 160;
    localparam int DEF_IMAGE_HEIGHT = 128;
    localparam int DEF_ADDR_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_WRITE,
        ST_DONE
    } wr_state_t;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchroniser for a quasi-static level crossing into Camera_PCLK.
module cdc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/frame_wr_ctrl.sv
// Camera pixel stream to frame-buffer write controller. Define FRAME_WR_DOUBLE_BUF_EN
// for ping-pong operation over two frames; otherwise a single buffer at base 0 is used.
module frame_wr_ctrl
    import frame_buf_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic              Camera_PCLK,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    input  logic              rd_bank,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              ready_bank,
    output logic              frame_done_tgl,
    output logic              short_err,
    output logic              ovf_err,
    output wr_state_t         state_dbg
);

    localparam int FRAME_PIXELS = frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int IDX_W        = $clog2(FRAME_PIXELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

    wr_state_t        state;
    logic [IDX_W-1:0] pix_idx;
    logic             wr_bank;
    logic             new_bank;
    logic             rd_bank_s;

    cdc_sync2 u_rd_bank_sync (
        .clk   (Camera_PCLK),
        .rst_n (rst_n),
        .d     (rd_bank),
        .q     (rd_bank_s)
    );

`ifdef FRAME_WR_DOUBLE_BUF_EN
    // Always fill the bank the display is not reading.
    assign new_bank = ~rd_bank_s;
`else
    logic unused_rd_bank_s;
    assign unused_rd_bank_s = rd_bank_s;
    assign new_bank         = 1'b0;
`endif

    assign state_dbg = state;

    function automatic logic [ADDR_W-1:0] addr_of(input logic bank, input logic [IDX_W-1:0] idx);
        return (bank ? ADDR_W'(FRAME_PIXELS) : '0) + ADDR_W'(idx);
    endfunction

    always_ff @(posedge Camera_PCLK or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            ready_bank     <= 1'b0;
            frame_done_tgl <= 1'b0;
            short_err      <= 1'b0;
            ovf_err        <= 1'b0;
            pix_idx        <= '0;
            wr_bank        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (!init_done) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_WAIT_SOF;
                    ST_WAIT_SOF: begin
                        if (pix_valid) ovf_err <= 1'b1;
                        if (frame_start) begin
                            state   <= ST_WRITE;
                            pix_idx <= '0;
                            wr_bank <= new_bank;
                        end
                    end
                    ST_WRITE: begin
                        if (frame_start) begin
                            // Restart takes priority; a coincident pixel becomes index 0 of the new frame.
                            short_err <= 1'b1;
                            wr_bank   <= new_bank;
                            pix_idx   <= '0;
                            if (pix_valid) begin
                                wr_en   <= 1'b1;
                                wr_data <= pix_data;
                                wr_addr <= addr_of(new_bank, '0);
                                pix_idx <= IDX_W'(1);
                            end
                        end else if (pix_valid) begin
                            wr_en   <= 1'b1;
                            wr_data <= pix_data;
                            wr_addr <= addr_of(wr_bank, pix_idx);
                            if (pix_idx == LAST_IDX) state <= ST_DONE;
                            else pix_idx <= pix_idx + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        ready_bank     <= wr_bank;
                        frame_done_tgl <= ~frame_done_tgl;
                        if (pix_valid) ovf_err <= 1'b1;
                        if (frame_start) begin
                            state   <= ST_WRITE;
                            pix_idx <= '0;
                            wr_bank <= new_bank;
                        end else begin
                            state <= ST_WAIT_SOF;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
